voice_frame_mixer: RTL and testbench
====================================

# voice_frame_mixer

Parametrised voice scheduler and frame mixer for the polyphonic synth datapath. Generates the time-multiplexed voice index and pipeline-stage count that drive the DDS / wavetable / ADSR chain, then accumulates the tagged per-voice samples returning from that chain into one mixed output sample per frame. Generalises the fixed 256-voice, 4-stage, wrap-only mixer:

- configurable voice count, stage count, widths and output scaling;
- per-voice mute mask;
- frame-valid strobe;
- optional saturation with clip flag.

## Interface
Parameters:
- NUM_VOICES, 256: voices per frame; power of two, 2..256. VI_W = log2(NUM_VOICES).
- STAGES, 4: clock cycles per voice slot; ≥2. ST_W = max(1, clog2(STAGES)).
- SAMPLE_W, 16: signed per-voice sample width.
- OUT_W, 24: signed mixed output width; ≤ ACC_W.
- SHIFT, 0: arithmetic right shift applied to the frame sum before output.
- ACC_W is internal and equals SAMPLE_W + VI_W.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  1 = scheduler advances; 0 = scheduler frozen.
- o_voice_index  out  VI_W  voice currently issued to the chain.
- o_pipeline_state  out  ST_W  stage within the current voice slot.
- i_sample  in  signed SAMPLE_W  sample returning from the ADSR stage.
- i_sample_valid  in  1  i_sample / i_sample_voice qualify this cycle.
- i_sample_voice  in  VI_W  voice tag of i_sample.
- i_mute_we  in  1  mute-mask write strobe.
- i_mute_voice  in  VI_W  voice addressed by the mute write.
- i_mute_value  in  1  1 = muted.
- o_mixed_sample  out  signed OUT_W  mixed frame sample; held between frames.
- o_sample_valid  out  1  one-cycle strobe, asserted when o_mixed_sample updates.
- o_clip  out  1  saturation occurred on this output; meaningful with o_sample_valid.

## Operation
- Scheduler, when i_enable=1:
  - o_pipeline_state counts 0..STAGES-1, then wraps to 0.
  - On that wrap, o_voice_index increments; NUM_VOICES-1 wraps to 0.
  - When i_enable=0, both hold their values.
- Accumulator:
  - On each i_sample_valid cycle, i_sample is sign-extended to ACC_W and added, unless mute[i_sample_voice]=1, in which case 0 is added.
  - At most one sample is accepted per cycle. The accumulator accepts samples regardless of i_enable, so the chain can drain.
- Frame end is a valid sample with i_sample_voice = NUM_VOICES-1:
  - sum = accumulator + that (mute-gated) sample.
  - Output value is sum >>> SHIFT, then reduced to OUT_W as defined under Configuration.
  - Accumulator clears to 0.
  - o_sample_valid=1 for exactly one cycle.
- Mute mask:
  - NUM_VOICES bits, all 0 on reset.
  - A write takes effect from the following cycle. A sample for the same voice in the same cycle uses the old mask value.
- Voice tags are not checked for ordering. A missing or duplicated voice is summed as received.

## Timing
- Reset values: o_voice_index=0, o_pipeline_state=0, o_mixed_sample=0, o_sample_valid=0, o_clip=0, accumulator=0, mute mask=0.
- First clock edge after reset deasserts: o_pipeline_state goes 0→1 if i_enable=1.
- Output latency: o_mixed_sample, o_sample_valid and o_clip are registered. They update on the edge that samples the frame-end input and are visible the following cycle (1-cycle latency).
- o_mixed_sample is stable until the next frame end.
- Reset mid-frame: the partial accumulation is discarded, the mute mask is cleared, and the scheduler restarts at voice 0, stage 0.
- Back-to-back frame ends on consecutive cycles: each produces its own strobe. The second sum contains only its own sample.

## Configuration
- VOICE_MIXER_SATURATE_EN defined:
  - Shifted sum is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - o_clip=1 with o_sample_valid when clamping occurred.
- Not defined:
  - Shifted sum is truncated to its low OUT_W bits (two's-complement wrap).
  - o_clip is tied to 0.

## Test plan
All scenarios use NUM_VOICES=4, STAGES=4, SAMPLE_W=16, OUT_W=16, SHIFT=0.
- Reset and scheduler: reset released with i_enable=1 → stage sequence 0,1,2,3,0. Voice index steps 0→1 every 4 cycles and wraps 3→0 after 16 cycles. With i_enable=0 for 5 cycles, both hold. All outputs read 0 during reset.
- Basic mix: valid samples 100, 200, 300, 400 tagged voices 0..3 → o_mixed_sample=1000, o_sample_valid high for 1 cycle, the cycle after the voice-3 sample. The next frame of all zeros → 0.
- Saturation: 4 × 30000:
  - With SATURATE_EN → 32767, o_clip=1.
  - 4 × -30000 with SATURATE_EN → -32768, o_clip=1.
  - 4 × 30000 without the macro → -11072, o_clip=0.
- Mute: write mute[2]=1, then frame 100, 200, 300, 400 → 700. Mute write for voice 1 in the same cycle as the voice-1 sample → that sample is still included.
- Reset mid-frame: voices 0 and 1 accepted (500 and 600), reset pulsed, then frame 1, 2, 3, 4 → 10, with no contribution from 500 or 600.
- SHIFT=2 variant: frame 100, 200, 300, 400 → 250.

Source files
------------

// File: rtl/voice_frame_mixer.sv
// voice_frame_mixer: time-multiplexed voice scheduler plus per-frame sample mixer.
// The scheduler issues a voice index and stage count to the synthesis chain.
// The mixer sums the tagged samples that come back from the chain, applying a
// per-voice mute mask, and emits one mixed sample per frame.
// Optional build macro VOICE_MIXER_SATURATE_EN: clamp the output to OUT_W and flag
// clipping on o_clip. Without it the output wraps and o_clip is tied low.
module voice_frame_mixer #(
    parameter int unsigned NUM_VOICES = 256,
    parameter int unsigned STAGES     = 4,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned OUT_W      = 24,
    parameter int unsigned SHIFT      = 0,
    localparam int unsigned VI_W      = $clog2(NUM_VOICES),
    localparam int unsigned ST_W      = (STAGES > 2) ? $clog2(STAGES) : 1,
    localparam int unsigned ACC_W     = SAMPLE_W + VI_W
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_enable,
    output logic [VI_W-1:0]            o_voice_index,
    output logic [ST_W-1:0]            o_pipeline_state,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    input  logic                       i_sample_valid,
    input  logic [VI_W-1:0]            i_sample_voice,
    input  logic                       i_mute_we,
    input  logic [VI_W-1:0]            i_mute_voice,
    input  logic                       i_mute_value,
    output logic signed [OUT_W-1:0]    o_mixed_sample,
    output logic                       o_sample_valid,
    output logic                       o_clip
);

    logic [ST_W-1:0]          stage_q, stage_d;
    logic [VI_W-1:0]          voice_q, voice_d;
    logic [NUM_VOICES-1:0]    mute_q, mute_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  sample_ext, sample_gated, sum, shifted;
    logic signed [OUT_W-1:0]  mixed_q, mixed_d, out_value;
    logic                     valid_q;
    logic                     frame_end;
    logic                     clip;

    // Scheduler next state: stage counts through the slot, voice advances on stage wrap.
    always_comb begin
        stage_d = stage_q;
        voice_d = voice_q;
        if (i_enable) begin
            if (stage_q == ST_W'(STAGES - 1)) begin
                stage_d = '0;
                voice_d = voice_q + 1'b1; // power-of-two voice count wraps naturally
            end else begin
                stage_d = stage_q + 1'b1;
            end
        end
    end

    // Mute mask update; samples in the same cycle still see the old mask.
    always_comb begin
        mute_d = mute_q;
        if (i_mute_we) begin
            mute_d[i_mute_voice] = i_mute_value;
        end
    end

    assign sample_ext   = {{VI_W{i_sample[SAMPLE_W-1]}}, i_sample};
    assign sample_gated = (i_sample_valid && !mute_q[i_sample_voice]) ? sample_ext : '0;
    assign sum          = acc_q + sample_gated;
    assign shifted      = sum >>> SHIFT;
    assign frame_end    = i_sample_valid && (i_sample_voice == VI_W'(NUM_VOICES - 1));

`ifdef VOICE_MIXER_SATURATE_EN
    localparam logic signed [ACC_W-1:0] OutMax = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OutMin = {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Reduce the shifted frame sum to OUT_W by clamping to the signed output range.
    always_comb begin
        out_value = shifted[OUT_W-1:0];
        clip      = 1'b0;
        if (shifted > OutMax) begin
            out_value = OutMax[OUT_W-1:0];
            clip      = 1'b1;
        end else if (shifted < OutMin) begin
            out_value = OutMin[OUT_W-1:0];
            clip      = 1'b1;
        end
    end
`else
    logic unused_shift_hi;

    // Reduce the shifted frame sum to OUT_W by two's-complement truncation.
    always_comb begin
        out_value = shifted[OUT_W-1:0];
        clip      = 1'b0;
    end
    assign unused_shift_hi = ^{shifted, clip};
`endif

    // Accumulator and output hold: frame end clears the sum and latches a new output.
    always_comb begin
        acc_d   = sum;
        mixed_d = mixed_q;
        if (frame_end) begin
            acc_d   = '0;
            mixed_d = out_value;
        end
    end

    // State registers for scheduler, mute mask, accumulator and output sample.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stage_q <= '0;
            voice_q <= '0;
            mute_q  <= '0;
            acc_q   <= '0;
            mixed_q <= '0;
            valid_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            voice_q <= voice_d;
            mute_q  <= mute_d;
            acc_q   <= acc_d;
            mixed_q <= mixed_d;
            valid_q <= frame_end;
        end
    end

`ifdef VOICE_MIXER_SATURATE_EN
    logic clip_q;

    // Clip flag accompanies the output strobe only.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            clip_q <= 1'b0;
        end else begin
            clip_q <= frame_end & clip;
        end
    end
    assign o_clip = clip_q;
`else
    assign o_clip = 1'b0;
`endif

    assign o_voice_index    = voice_q;
    assign o_pipeline_state = stage_q;
    assign o_mixed_sample   = mixed_q;
    assign o_sample_valid   = valid_q;

endmodule

// File: tb/tb_voice_frame_mixer.sv
// Scoreboard bench for voice_frame_mixer: a SHIFT=0 and a SHIFT=2 instance share stimulus.
module tb_voice_frame_mixer;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic signed [15:0] sample;
    logic sample_valid;
    logic [1:0] sample_voice;
    logic mute_we;
    logic [1:0] mute_voice;
    logic mute_value;

    logic [1:0] voice0, voice1;
    logic [1:0] stage0, stage1;
    logic signed [15:0] mixed0, mixed1;
    logic valid0, valid1, clip0, clip1;

    int checks = 0;
    int errors = 0;
    int q_val0[$], q_val1[$];
    bit q_clip0[$], q_clip1[$];

`ifdef VOICE_MIXER_SATURATE_EN
    localparam int PosE = 32767;
    localparam int PosC = 1;
    localparam int NegE = -32768;
    localparam int NegC = 1;
`else
    localparam int PosE = -11072;
    localparam int PosC = 0;
    localparam int NegE = 11072;
    localparam int NegC = 0;
`endif

    always #5 clk = ~clk;

    voice_frame_mixer #(
        .NUM_VOICES(4), .STAGES(4), .SAMPLE_W(16), .OUT_W(16), .SHIFT(0)
    ) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_enable(enable),
        .o_voice_index(voice0), .o_pipeline_state(stage0),
        .i_sample(sample), .i_sample_valid(sample_valid), .i_sample_voice(sample_voice),
        .i_mute_we(mute_we), .i_mute_voice(mute_voice), .i_mute_value(mute_value),
        .o_mixed_sample(mixed0), .o_sample_valid(valid0), .o_clip(clip0)
    );

    voice_frame_mixer #(
        .NUM_VOICES(4), .STAGES(4), .SAMPLE_W(16), .OUT_W(16), .SHIFT(2)
    ) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_enable(enable),
        .o_voice_index(voice1), .o_pipeline_state(stage1),
        .i_sample(sample), .i_sample_valid(sample_valid), .i_sample_voice(sample_voice),
        .i_mute_we(mute_we), .i_mute_voice(mute_voice), .i_mute_value(mute_value),
        .o_mixed_sample(mixed1), .o_sample_valid(valid1), .o_clip(clip1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever a DUT strobes an output.
    always @(negedge clk) begin : monitor
        int e;
        bit c;
        if (!rst && valid0) begin
            if (q_val0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mix0_unexpected: got strobe value %0d, expected no strobe", mixed0);
            end else begin
                e = q_val0.pop_front();
                c = q_clip0.pop_front();
                chk("mix0", int'(mixed0), e);
                chk("clip0", int'(clip0), int'(c));
            end
        end
        if (!rst && valid1) begin
            if (q_val1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mix1_unexpected: got strobe value %0d, expected no strobe", mixed1);
            end else begin
                e = q_val1.pop_front();
                c = q_clip1.pop_front();
                chk("mix1", int'(mixed1), e);
                chk("clip1", int'(clip1), int'(c));
            end
        end
    end

    task automatic push_exp(input int e0, input bit c0, input int e1);
        q_val0.push_back(e0);
        q_clip0.push_back(c0);
        q_val1.push_back(e1);
        q_clip1.push_back(1'b0);
    endtask

    task automatic smp(input int v, input int s, input bit mwe, input int mv);
        sample_valid = 1'b1;
        sample_voice = 2'(v);
        sample       = 16'(s);
        mute_we      = mwe;
        mute_voice   = 2'(mv);
        mute_value   = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        mute_we      = 1'b0;
    endtask

    task automatic frame(input int a, input int b, input int c, input int d,
                         input int e0, input bit c0, input int e1);
        smp(0, a, 1'b0, 0);
        smp(1, b, 1'b0, 0);
        smp(2, c, 1'b0, 0);
        push_exp(e0, c0, e1);
        smp(3, d, 1'b0, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int sv, ss;
        rst = 1'b1;
        enable = 1'b1;
        sample = '0;
        sample_valid = 1'b0;
        sample_voice = '0;
        mute_we = 1'b0;
        mute_voice = '0;
        mute_value = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_voice", int'(voice0), 0);
        chk("rst_stage", int'(stage0), 0);
        chk("rst_mixed", int'(mixed0), 0);
        chk("rst_valid", int'(valid0), 0);
        chk("rst_clip", int'(clip0), 0);
        rst = 1'b0;

        // Scheduler: stage counts 0..3, voice steps every 4 cycles and wraps after 16.
        for (int k = 0; k < 20; k++) begin
            chk("sched_stage", int'(stage0), k % 4);
            chk("sched_voice", int'(voice0), (k / 4) % 4);
            @(negedge clk);
        end
        enable = 1'b0;
        sv = int'(voice0);
        ss = int'(stage0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_stage", int'(stage0), ss);
            chk("hold_voice", int'(voice1), sv);
        end
        enable = 1'b1;

        frame(100, 200, 300, 400, 1000, 1'b0, 250);
        frame(0, 0, 0, 0, 0, 1'b0, 0);
        frame(30000, 30000, 30000, 30000, PosE, 1'(PosC), 30000);
        frame(-30000, -30000, -30000, -30000, NegE, 1'(NegC), -30000);

        // Mute voice 2, then mute voice 1 in the same cycle as its sample.
        smp(0, 0, 1'b1, 2);
        @(negedge clk);
        frame(100, 200, 300, 400, 700, 1'b0, 175);
        smp(0, 10, 1'b0, 0);
        smp(1, 20, 1'b1, 1);
        smp(2, 30, 1'b0, 0);
        push_exp(70, 1'b0, 17);
        smp(3, 40, 1'b0, 0);
        repeat (2) @(negedge clk);
        frame(10, 20, 30, 40, 50, 1'b0, 12);

        // Reset mid-frame discards partial sum and clears the mute mask.
        smp(0, 500, 1'b0, 0);
        smp(1, 600, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mixed", int'(mixed0), 0);
        chk("midrst_stage", int'(stage0), 0);
        rst = 1'b0;
        frame(1, 2, 3, 4, 10, 1'b0, 2);

        // Back-to-back frame ends.
        smp(0, 5, 1'b0, 0);
        push_exp(12, 1'b0, 3);
        smp(3, 7, 1'b0, 0);
        push_exp(9, 1'b0, 2);
        smp(3, 9, 1'b0, 0);
        repeat (3) @(negedge clk);

        for (int k = 0; k < 10 && (q_val0.size() != 0 || q_val1.size() != 0); k++) begin
            @(negedge clk);
        end
        checks++;
        if (q_val0.size() != 0 || q_val1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, expected 0", q_val0.size(), q_val1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
